// File: rtl/pong_pkg.sv
// pong_pkg: shared ball FSM states, default screen size and RGB332 colour type.
package pong_pkg;
  typedef enum logic {SERVE, MOVE} ball_state_t;
  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 600;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
endpackage

// File: rtl/ball_axis.sv
// ball_axis: one ball axis, holding position and direction, with bounce/clamp at both walls.
module ball_axis #(
  parameter int W     = 12,
  parameter int LIMIT = 800,
  parameter int SIZE  = 21,
  parameter int SPEED = 2,
  parameter int START = 300
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_step,
  input  logic         i_flip,
  input  logic         i_serve,
  input  logic         i_serve_dir,
  output logic [W-1:0] o_pos,
  output logic         o_dir,
  output logic         o_lo,
  output logic         o_hi
);
  localparam logic [W-1:0] L_START = W'(START);
  localparam logic [W-1:0] L_MAX   = W'(LIMIT - SIZE);
  localparam logic [W-1:0] L_SPD   = W'(SPEED);
  localparam logic [W:0]   L_ADD   = (W+1)'(SIZE + SPEED);
  localparam logic [W:0]   L_LIM   = (W+1)'(LIMIT);
  logic [W-1:0] r_pos;
  logic         r_dir;
  logic         w_dir;
  // Wall flags use the direction after any paddle flip, one bit wider so the sum never wraps
  assign w_dir = r_dir ^ i_flip;
  assign o_hi  = w_dir && ({1'b0, r_pos} + L_ADD >= L_LIM);
  assign o_lo  = !w_dir && (r_pos < L_SPD);
  assign o_pos = r_pos;
  assign o_dir = r_dir;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pos <= L_START;
      r_dir <= 1'b1;
    end else if (i_serve) begin
      r_pos <= L_START;
      r_dir <= i_serve_dir;
    end else if (i_step) begin
      r_pos <= o_hi ? L_MAX : o_lo ? '0 : w_dir ? r_pos + L_SPD : r_pos - L_SPD;
      r_dir <= (o_hi || o_lo) ? !w_dir : w_dir;
    end
endmodule

// File: rtl/ball_mover.sv
// ball_mover: per-frame moving ball with serve hold and wall bounce.
// Define BALL_PADDLE_EN for paddle hits and left/right miss reporting.
module ball_mover
  import pong_pkg::*;
#(
  parameter int      H_ACTIVE     = H_ACTIVE_DEF,
  parameter int      V_ACTIVE     = V_ACTIVE_DEF,
  parameter int      BALL_SIZE    = 21,
  parameter int      START_X      = 300,
  parameter int      START_Y      = 220,
  parameter int      SPEED_X      = 2,
  parameter int      SPEED_Y      = 2,
  parameter int      SERVE_FRAMES = 60,
  parameter rgb332_t BALL_RGB     = 8'b101_011_01
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] hcount,
  input  logic [10:0] vcount,
  input  logic        drawPaddle,
  output logic        drawBall,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        miss_left,
  output logic        miss_right
);
  localparam int CW = $clog2(SERVE_FRAMES + 1);
  ball_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic          r_draw, r_miss_l, r_miss_r;
  rgb332_t       r_rgb;
  logic          w_tick, w_move, w_hit, w_miss_l, w_miss_r, w_in;
  logic [11:0]   w_x;
  logic [10:0]   w_y;
  logic          w_xdir, w_ydir, w_xlo, w_xhi, w_ylo, w_yhi;
  assign w_tick = hcount == 12'd0 && vcount == 11'(V_ACTIVE);
  assign w_move = w_tick && r_state == MOVE;
`ifdef BALL_PADDLE_EN
  logic r_hit;
  assign w_hit    = r_hit;
  assign w_miss_l = w_move && w_xlo && !r_hit;
  assign w_miss_r = w_move && w_xhi && !r_hit;
  // drawBall is already one cycle late, so it pairs with the current paddle input
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_hit <= 1'b0;
    else r_hit <= w_move ? 1'b0 : r_hit | (r_draw & drawPaddle);
`else
  logic w_unused_paddle;
  assign w_unused_paddle = drawPaddle;
  assign w_hit    = 1'b0;
  assign w_miss_l = 1'b0;
  assign w_miss_r = 1'b0;
`endif
  ball_axis #(.W(12), .LIMIT(H_ACTIVE), .SIZE(BALL_SIZE), .SPEED(SPEED_X), .START(START_X)) u_x (
    .clk(clk), .rst_n(rst_n), .i_step(w_move), .i_flip(w_move && w_hit),
    .i_serve(w_miss_l || w_miss_r), .i_serve_dir(w_miss_l),
    .o_pos(w_x), .o_dir(w_xdir), .o_lo(w_xlo), .o_hi(w_xhi)
  );
  ball_axis #(.W(11), .LIMIT(V_ACTIVE), .SIZE(BALL_SIZE), .SPEED(SPEED_Y), .START(START_Y)) u_y (
    .clk(clk), .rst_n(rst_n), .i_step(w_move), .i_flip(1'b0),
    .i_serve(w_miss_l || w_miss_r), .i_serve_dir(w_ydir),
    .o_pos(w_y), .o_dir(w_ydir), .o_lo(w_ylo), .o_hi(w_yhi)
  );
  logic w_unused_flags;
  assign w_unused_flags = w_xdir ^ w_ylo ^ w_yhi;
  assign w_in = hcount >= w_x && {1'b0, hcount} <= {1'b0, w_x} + 13'(BALL_SIZE - 1)
             && vcount >= w_y && {1'b0, vcount} <= {1'b0, w_y} + 12'(BALL_SIZE - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= SERVE;
      r_cnt    <= '0;
      r_draw   <= 1'b0;
      r_miss_l <= 1'b0;
      r_miss_r <= 1'b0;
      r_rgb    <= BALL_RGB;
    end else begin
      r_draw   <= w_in;
      r_miss_l <= w_miss_l;
      r_miss_r <= w_miss_r;
      r_rgb    <= BALL_RGB;
      if (w_tick && r_state == SERVE) begin
        r_cnt   <= r_cnt == CW'(SERVE_FRAMES - 1) ? '0 : r_cnt + 1'b1;
        r_state <= r_cnt == CW'(SERVE_FRAMES - 1) ? MOVE : SERVE;
      end else if (w_miss_l || w_miss_r) r_state <= SERVE;
    end
  assign drawBall   = r_draw;
  assign miss_left  = r_miss_l;
  assign miss_right = r_miss_r;
  assign red        = r_rgb.r;
  assign green      = r_rgb.g;
  assign blue       = r_rgb.b;
endmodule

// File: tb/tb_ball_mover.sv
// tb_ball_mover: directed frame ticks against a reference ball model, probing drawBall via a scoreboard.
module tb_ball_mover;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic        drawPaddle;
  logic        drawBall, miss_left, miss_right;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  int checks = 0, errors = 0;
  logic q[$];
  int mx, my, sc;
  logic mdx, mdy, mserve;

  ball_mover dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .drawPaddle(drawPaddle),
    .drawBall(drawBall), .red(red), .green(green), .blue(blue),
    .miss_left(miss_left), .miss_right(miss_right)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hcount = 12'd4000;
    vcount = 11'd2000;
  endtask

  task automatic model_reset();
    mx = 300; my = 220; mdx = 1'b1; mdy = 1'b1; mserve = 1'b1; sc = 0;
  endtask

  task automatic model_tick(input logic hit, output logic ml, output logic mr);
    logic d, lo, hi, oldy;
    ml = 1'b0; mr = 1'b0; lo = 1'b0; hi = 1'b0;
    if (mserve) begin
      sc++;
      if (sc == 60) begin mserve = 1'b0; sc = 0; end
    end else begin
      oldy = mdy;
      d = mdx ^ hit;
      if (d) begin
        if (mx + 23 >= 800) begin mx = 779; d = 1'b0; hi = 1'b1; end else mx += 2;
      end else begin
        if (mx < 2) begin mx = 0; d = 1'b1; lo = 1'b1; end else mx -= 2;
      end
      mdx = d;
      if (mdy) begin
        if (my + 23 >= 600) begin my = 579; mdy = 1'b0; end else my += 2;
      end else begin
        if (my < 2) begin my = 0; mdy = 1'b1; end else my -= 2;
      end
`ifdef BALL_PADDLE_EN
      if (!hit && (lo || hi)) begin
        ml = lo; mr = hi; mserve = 1'b1; mx = 300; my = 220; mdx = lo; mdy = oldy;
      end
`endif
    end
  endtask

  task automatic probe(input int h, input int v, input logic e);
    @(negedge clk);
    hcount = 12'(h);
    vcount = 11'(v);
    q.push_back(e);
    @(negedge clk);
    idle();
    chk($sformatf("draw(%0d,%0d)", h, v), {7'd0, drawBall}, {7'd0, q.pop_front()});
  endtask

  task automatic check_pos(input int x, input int y);
    probe(x, y, 1'b1);
    probe(x + 20, y + 20, 1'b1);
    if (x > 0) probe(x - 1, y, 1'b0);
    probe(x + 21, y, 1'b0);
    if (y > 0) probe(x + 5, y - 1, 1'b0);
    probe(x + 5, y + 21, 1'b0);
  endtask

  task automatic tick(input logic hit);
    logic ml, mr;
    model_tick(hit, ml, mr);
    @(negedge clk);
    hcount = 12'd0;
    vcount = 11'd600;
    @(negedge clk);
    idle();
    chk("miss_left", {7'd0, miss_left}, {7'd0, ml});
    chk("miss_right", {7'd0, miss_right}, {7'd0, mr});
    if (ml || mr) begin
      @(negedge clk);
      chk("miss_left_end", {7'd0, miss_left}, 8'd0);
      chk("miss_right_end", {7'd0, miss_right}, 8'd0);
    end
  endtask

  initial begin
    logic hit_done;
    int n;
    hit_done = 1'b0;
    idle();
    drawPaddle = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_draw", {7'd0, drawBall}, 8'd0);
    chk("reset_rgb", {red, green, blue}, 8'hAD);
    chk("reset_miss", {6'd0, miss_left, miss_right}, 8'd0);
    rst_n = 1'b1;
    check_pos(300, 220);
    for (int i = 1; i <= 59; i++) begin
      tick(1'b0);
      if (i == 1 || i == 59) check_pos(300, 220);
    end
    tick(1'b0);
    check_pos(300, 220);
    tick(1'b0);
    check_pos(302, 222);
    @(negedge clk);
    hcount = 12'd310;
    vcount = 11'd230;
    @(negedge clk);
    idle();
    chk("pre_reset_draw", {7'd0, drawBall}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_draw", {7'd0, drawBall}, 8'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_pos(300, 220);
`ifdef BALL_PADDLE_EN
    n = 1080;
`else
    n = 245;
`endif
    for (int i = 0; i < n; i++) begin
`ifdef BALL_PADDLE_EN
      if (!hit_done && !mserve && !mdx && mx == 100) begin
        hit_done = 1'b1;
        @(negedge clk);
        hcount = 12'(mx);
        vcount = 11'(my);
        @(negedge clk);
        idle();
        drawPaddle = 1'b1;
        chk("hit_draw", {7'd0, drawBall}, 8'd1);
        @(negedge clk);
        drawPaddle = 1'b0;
        tick(1'b1);
      end else tick(1'b0);
`else
      tick(1'b0);
`endif
      check_pos(mx, my);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
